// File: rtl/key_debouncer_if.sv
// Purpose: bundles the per-key raw inputs and the debounced level/tick outputs of key_debouncer.
// Latency: none, wiring only.
// Backpressure: none; ticks are single-cycle strobes that the consumer must sample every cycle.
interface key_debouncer_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_n_in;
    logic [N_KEYS-1:0] key_n_out;
    logic [N_KEYS-1:0] press_tick;
    logic [N_KEYS-1:0] release_tick;

    // Stimulus/consumer side: drives raw keys, observes debounced results
    modport master (
        output key_n_in,
        input  key_n_out,
        input  press_tick,
        input  release_tick
    );

    // Debouncer side
    modport slave (
        input  key_n_in,
        output key_n_out,
        output press_tick,
        output release_tick
    );
endinterface

// File: rtl/key_debouncer.sv
// Purpose: per-key two-flop synchronizer plus UP/WAIT_DOWN/DOWN/WAIT_UP debounce FSM with press/release ticks.
// Latency: a stable raw level change reaches key_n_out 2+DEBOUNCE_CYCLES edges after first being sampled.
// Backpressure: none; ticks are one-cycle strobes. Define KEY_AUTOREPEAT_EN to add hold-to-repeat press ticks.
module key_debouncer #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic            CLOCK_50_B5B,
    input  logic            reset,
    key_debouncer_if.slave  kif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_UP        = 2'd0,
        ST_WAIT_DOWN = 2'd1,
        ST_DOWN      = 2'd2,
        ST_WAIT_UP   = 2'd3
    } state_t;

    // Elaboration-time parameter sanity
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("key_debouncer: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("key_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    logic [N_KEYS-1:0] w_key_n_vec;
    logic [N_KEYS-1:0] w_press_vec;
    logic [N_KEYS-1:0] w_release_vec;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        logic             r_sync1;
        logic             r_sync2;
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] w_cnt_inc;
        logic             r_press;
        logic             r_release;
        logic             w_press_nxt;
        logic             w_release_nxt;
        logic             w_rpt;
        logic             w_key_n;
        logic             w_press;
        logic             w_release;

        // Two-flop synchronizer; idles at 1 (released) so reset never looks like a press
        always_ff @(posedge CLOCK_50_B5B) begin
            if (reset) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
            end else begin
                r_sync1 <= kif.key_n_in[g];
                r_sync2 <= r_sync1;
            end
        end

        // State register: FSM state, debounce counter and the registered entry strobes
        always_ff @(posedge CLOCK_50_B5B) begin
            if (reset) begin
                r_state   <= ST_UP;
                r_cnt     <= '0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_press   <= w_press_nxt;
                r_release <= w_release_nxt;
            end
        end

        // Next-state logic: count consecutive opposite-level samples, any reversal abandons the attempt
        always_comb begin
            w_state_nxt   = r_state;
            w_cnt_nxt     = r_cnt;
            w_press_nxt   = 1'b0;
            w_release_nxt = 1'b0;
            // Saturating increment so the counter can never wrap
            w_cnt_inc     = (r_cnt == DEB_MAX) ? r_cnt : r_cnt + CNT_ONE;
            case (r_state)
                ST_UP: begin
                    if (!r_sync2) begin
                        w_state_nxt = ST_WAIT_DOWN;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                ST_WAIT_DOWN: begin
                    if (r_sync2) begin
                        w_state_nxt = ST_UP;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == DEB_MAX) begin
                        w_state_nxt = ST_DOWN;
                        w_cnt_nxt   = '0;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                ST_DOWN: begin
                    if (r_sync2) begin
                        w_state_nxt = ST_WAIT_UP;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                ST_WAIT_UP: begin
                    if (!r_sync2) begin
                        // Bounce back to held: not a new press, so no tick
                        w_state_nxt = ST_DOWN;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == DEB_MAX) begin
                        w_state_nxt   = ST_UP;
                        w_cnt_nxt     = '0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt     = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_UP;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

`ifdef KEY_AUTOREPEAT_EN
        localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
        localparam logic [HOLD_W-1:0] RPT_DELAY  = HOLD_W'(REPEAT_DELAY);
        localparam logic [HOLD_W-1:0] RPT_PERIOD = HOLD_W'(REPEAT_PERIOD);

        logic [HOLD_W-1:0] r_hold;
        logic [HOLD_W-1:0] w_hold_nxt;
        logic [HOLD_W-1:0] w_hold_inc;
        logic [HOLD_W-1:0] w_target;
        logic              r_first;
        logic              w_first_nxt;
        logic              r_rpt;
        logic              w_rpt_nxt;
        logic              w_held_now;
        logic              w_held_nxt;

        // Hold counter register: cycles since the press (or since the last repeat)
        always_ff @(posedge CLOCK_50_B5B) begin
            if (reset) begin
                r_hold  <= '0;
                r_first <= 1'b1;
                r_rpt   <= 1'b0;
            end else begin
                r_hold  <= w_hold_nxt;
                r_first <= w_first_nxt;
                r_rpt   <= w_rpt_nxt;
            end
        end

        // Repeat scheduling: first tick after REPEAT_DELAY, then every REPEAT_PERIOD while held
        always_comb begin
            w_hold_nxt  = r_hold;
            w_first_nxt = r_first;
            w_rpt_nxt   = 1'b0;
            w_hold_inc  = r_hold + 1'b1;
            w_target    = r_first ? RPT_DELAY : RPT_PERIOD;
            w_held_now  = (r_state == ST_DOWN) || (r_state == ST_WAIT_UP);
            w_held_nxt  = (w_state_nxt == ST_DOWN) || (w_state_nxt == ST_WAIT_UP);
            if (w_press_nxt) begin
                w_hold_nxt  = '0;
                w_first_nxt = 1'b1;
            end else if (w_held_now && w_held_nxt) begin
                if (w_hold_inc == w_target) begin
                    // Counter restarts at every tick, so it never exceeds the larger target
                    w_hold_nxt  = '0;
                    w_first_nxt = 1'b0;
                    w_rpt_nxt   = 1'b1;
                end else begin
                    w_hold_nxt  = w_hold_inc;
                end
            end else begin
                // Released (or never held): repeats stop at once
                w_hold_nxt  = '0;
                w_first_nxt = 1'b1;
            end
        end

        assign w_rpt = r_rpt;
`else
        assign w_rpt = 1'b0;
`endif

        // Moore outputs: level follows the accepted state, ticks come from registered entry strobes
        always_comb begin
            w_key_n   = 1'b1;
            if ((r_state == ST_DOWN) || (r_state == ST_WAIT_UP)) begin
                w_key_n = 1'b0;
            end
            w_press   = r_press | w_rpt;
            w_release = r_release;
        end

        assign w_key_n_vec[g]   = w_key_n;
        assign w_press_vec[g]   = w_press;
        assign w_release_vec[g] = w_release;
    end

    assign kif.key_n_out    = w_key_n_vec;
    assign kif.press_tick   = w_press_vec;
    assign kif.release_tick = w_release_vec;

endmodule
